// File: rtl/uart_rx_ctrl_if.sv
// Receiver-side and consumer-side signals of the UART receive controller.
// The controller connects through the slave modport. The surrounding logic connects through master.
interface uart_rx_ctrl_if #(
  parameter int DATA_BITS = 8
);
  logic                 rx_done;
  logic                 rx_busy;
  logic                 rx_error;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_en;
  logic                 rx_rst;
  logic                 rd_valid;
  logic                 rd_ready;
  logic [DATA_BITS-1:0] rd_data;

  modport slave (
    input  rx_done, rx_busy, rx_error, rx_data, rd_ready,
    output rx_en, rx_rst, rd_valid, rd_data
  );

  modport master (
    output rx_done, rx_busy, rx_error, rx_data, rd_ready,
    input  rx_en, rx_rst, rd_valid, rd_data
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: sequences receiver enable/reset and buffers received
// characters in a show-ahead FIFO with overrun, framing-error and idle-timeout status.
module uart_rx_ctrl #(
  parameter int DATA_BITS    = 8,
  parameter int FIFO_DEPTH   = 8,
  parameter int RST_CYCLES   = 4,
  parameter int TIMEOUT_CLKS = 416640
) (
  input  logic                          clk,
  input  logic                          arst_n,
  input  logic                          ctrl_en,
  input  logic                          ctrl_flush,
  input  logic                          err_clr,
  uart_rx_ctrl_if.slave                 bus,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overrun_flag,
  output logic                          frame_err_flag,
  output logic                          timeout_irq
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CLKS);

  typedef enum logic [1:0] {S_OFF, S_RST, S_RUN, S_STOP} state_t;

  state_t               state_q, state_d;
  logic [RW-1:0]        rst_cnt_q;
  logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [TW-1:0]        to_cnt_q;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];

  logic capture, full, do_pop, do_push, ovr_set, ferr_set;

  // ---------------- control FSM ----------------
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_OFF:  if (ctrl_en) state_d = S_RST;
      S_RST:  if (rst_cnt_q == RW'(RST_CYCLES - 1)) state_d = ctrl_en ? S_RUN : S_OFF;
      S_RUN:  if (!ctrl_en) state_d = S_STOP;
      S_STOP: if (!bus.rx_busy) state_d = S_OFF;
      default: state_d = S_OFF;
    endcase
    // Flush overrides every other transition, including from RST back into RST.
    if (ctrl_flush) state_d = ctrl_en ? S_RST : S_OFF;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q   <= S_OFF;
      rst_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      rst_cnt_q <= (state_q == S_RST && state_d == S_RST && !ctrl_flush)
                   ? rst_cnt_q + RW'(1) : '0;
    end
  end

  assign bus.rx_en  = (state_q == S_RUN);
  assign bus.rx_rst = (state_q == S_RST);

  // ---------------- receive FIFO ----------------
  assign capture  = bus.rx_done && (state_q == S_RUN || state_q == S_STOP);
  assign full     = (fifo_count == CW'(FIFO_DEPTH));
  assign do_pop   = bus.rd_valid && bus.rd_ready;
  assign do_push  = capture && !bus.rx_error && !ctrl_flush && (!full || do_pop);
  assign ovr_set  = capture && !bus.rx_error && !ctrl_flush && full && !do_pop;
  assign ferr_set = capture && bus.rx_error;

  // NOTE: storage has no reset; emptiness is tracked by the pointers and count alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= bus.rx_data;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_count <= '0;
    end else if (ctrl_flush) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_count <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (do_push && !do_pop)      fifo_count <= fifo_count + CW'(1);
      else if (do_pop && !do_push) fifo_count <= fifo_count - CW'(1);
    end
  end

  assign bus.rd_valid = (fifo_count != '0);
  // Empty reads as zero so the output is defined without resetting the storage.
  assign bus.rd_data  = bus.rd_valid ? mem[rd_ptr_q] : '0;

  // ---------------- idle timeout and status ----------------
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      to_cnt_q    <= '0;
      timeout_irq <= 1'b0;
    end else begin
      if (ctrl_flush || do_push || do_pop || fifo_count == '0)
        to_cnt_q <= '0;
      else if (!bus.rx_busy && to_cnt_q != TW'(TIMEOUT_CLKS - 1))
        to_cnt_q <= to_cnt_q + TW'(1);

      if (ctrl_flush || do_push || do_pop)       timeout_irq <= 1'b0;
      else if (to_cnt_q == TW'(TIMEOUT_CLKS - 1)) timeout_irq <= 1'b1;
    end
  end

  // Sticky error flags: a set event beats a same-cycle clear; flush leaves them alone.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      overrun_flag   <= 1'b0;
      frame_err_flag <= 1'b0;
    end else begin
      if (ovr_set)      overrun_flag <= 1'b1;
      else if (err_clr) overrun_flag <= 1'b0;
      if (ferr_set)     frame_err_flag <= 1'b1;
      else if (err_clr) frame_err_flag <= 1'b0;
    end
  end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed and randomized bench for uart_rx_ctrl, compared every cycle against a
// queue-based reference model of the receive controller.
module tb_uart_rx_ctrl;
  localparam int DB    = 8;
  localparam int DEPTH = 8;
  localparam int RSTC  = 4;
  localparam int TO    = 40;
  localparam int CW    = $clog2(DEPTH) + 1;

  localparam int M_OFF = 0, M_RST = 1, M_RUN = 2, M_STOP = 3;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  logic ctrl_en, ctrl_flush, err_clr;
  logic [CW-1:0] fifo_count;
  logic overrun_flag, frame_err_flag, timeout_irq;

  uart_rx_ctrl_if #(.DATA_BITS(DB)) bus ();

  uart_rx_ctrl #(
    .DATA_BITS(DB), .FIFO_DEPTH(DEPTH), .RST_CYCLES(RSTC), .TIMEOUT_CLKS(TO)
  ) dut (
    .clk(clk), .arst_n(arst_n), .ctrl_en(ctrl_en), .ctrl_flush(ctrl_flush),
    .err_clr(err_clr), .bus(bus), .fifo_count(fifo_count),
    .overrun_flag(overrun_flag), .frame_err_flag(frame_err_flag),
    .timeout_irq(timeout_irq)
  );

  always #5 clk = ~clk;

  // Reference model state
  int         m_mode, m_rst_left, m_idle;
  logic [7:0] m_q[$];
  bit         m_ovr, m_ferr, m_irq;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_mode = M_OFF; m_rst_left = 0; m_idle = 0;
    m_ovr = 0; m_ferr = 0; m_irq = 0;
  endtask

  // Applies one clock edge to the model using the inputs that were present before it.
  task automatic model_step();
    int sz      = m_q.size();
    bit pop     = (sz != 0) && bus.rd_ready;
    bit cap     = bus.rx_done && (m_mode == M_RUN || m_mode == M_STOP);
    bit good    = cap && !bus.rx_error;
    bit wr      = good && !ctrl_flush && (sz < DEPTH || pop);
    bit ovr_evt = good && !ctrl_flush && sz == DEPTH && !pop;
    bit fe_evt  = cap && bus.rx_error;

    if (ovr_evt) m_ovr = 1; else if (err_clr) m_ovr = 0;
    if (fe_evt)  m_ferr = 1; else if (err_clr) m_ferr = 0;

    if (ctrl_flush) begin
      m_q.delete(); m_idle = 0; m_irq = 0;
      m_mode = ctrl_en ? M_RST : M_OFF;
      m_rst_left = RSTC;
    end else begin
      if (wr || pop) m_irq = 0;
      else if (m_idle == TO - 1) m_irq = 1;
      if (wr || pop || sz == 0) m_idle = 0;
      else if (!bus.rx_busy && m_idle < TO - 1) m_idle++;
      if (pop) void'(m_q.pop_front());
      if (wr)  m_q.push_back(bus.rx_data);
      case (m_mode)
        M_OFF:  if (ctrl_en) begin m_mode = M_RST; m_rst_left = RSTC; end
        M_RST:  begin
                  m_rst_left--;
                  if (m_rst_left == 0) m_mode = ctrl_en ? M_RUN : M_OFF;
                end
        M_RUN:  if (!ctrl_en) m_mode = M_STOP;
        default: if (!bus.rx_busy) m_mode = M_OFF;
      endcase
    end
  endtask

  task automatic check_all();
    check("rx_en",     bus.rx_en,    (m_mode == M_RUN));
    check("rx_rst",    bus.rx_rst,   (m_mode == M_RST));
    check("rd_valid",  bus.rd_valid, (m_q.size() != 0));
    check("rd_data",   bus.rd_data,  (m_q.size() != 0) ? m_q[0] : 8'h00);
    check("fifo_count", fifo_count,  m_q.size());
    check("overrun",   overrun_flag,   m_ovr);
    check("frame_err", frame_err_flag, m_ferr);
    check("timeout",   timeout_irq,    m_irq);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic push(input logic [7:0] d, input logic err);
    bus.rx_data = d; bus.rx_error = err; bus.rx_done = 1'b1;
    cycle();
    bus.rx_done = 1'b0; bus.rx_error = 1'b0;
  endtask

  initial begin
    int n_rst;
    ctrl_en = 0; ctrl_flush = 0; err_clr = 0;
    bus.rx_done = 0; bus.rx_busy = 0; bus.rx_error = 0; bus.rx_data = '0; bus.rd_ready = 0;
    model_reset();

    // Reset state
    #12;
    check_all();
    @(negedge clk); arst_n = 1'b1;
    cycle(); cycle();

    // Enable: exactly RSTC cycles of rx_rst, then rx_en
    ctrl_en = 1; n_rst = 0;
    for (int i = 0; i < RSTC + 4; i++) begin
      cycle();
      if (bus.rx_rst === 1'b1) n_rst++;
    end
    check("rst_len", n_rst, RSTC);
    check("run_en", bus.rx_en, 1'b1);

    // Two pushes, then one pop
    push(8'hA5, 0); push(8'h3C, 0);
    check("two_cnt", fifo_count, 2);
    check("two_head", bus.rd_data, 8'hA5);
    bus.rd_ready = 1; cycle(); bus.rd_ready = 0;
    check("pop_head", bus.rd_data, 8'h3C);
    check("pop_cnt", fifo_count, 1);
    bus.rd_ready = 1; cycle(); bus.rd_ready = 0;

    // Overrun on the ninth write, then full write-with-pop
    for (int i = 1; i <= 9; i++) push(8'(i), 0);
    check("full_cnt", fifo_count, DEPTH);
    check("ovr_set", overrun_flag, 1'b1);
    err_clr = 1; cycle(); err_clr = 0;
    check("ovr_clr", overrun_flag, 1'b0);
    check("full_head", bus.rd_data, 8'h01);
    bus.rd_ready = 1; push(8'h09, 0); bus.rd_ready = 0;
    check("wrpop_cnt", fifo_count, DEPTH);
    check("wrpop_ovr", overrun_flag, 1'b0);
    for (int k = 2; k <= 9; k++) begin
      check("order", bus.rd_data, k);
      bus.rd_ready = 1; cycle(); bus.rd_ready = 0;
    end
    check("drained", bus.rd_valid, 1'b0);

    // Framing errors
    push(8'hFF, 1);
    check("fe_set", frame_err_flag, 1'b1);
    check("fe_cnt", fifo_count, 0);
    err_clr = 1; push(8'h11, 1); err_clr = 0;
    check("fe_setwins", frame_err_flag, 1'b1);
    err_clr = 1; cycle(); err_clr = 0;
    check("fe_clr", frame_err_flag, 1'b0);

    // Idle timeout
    push(8'h5A, 0);
    repeat (TO - 1) cycle();
    check("to_early", timeout_irq, 1'b0);
    cycle();
    check("to_fire", timeout_irq, 1'b1);
    bus.rd_ready = 1; cycle(); bus.rd_ready = 0;
    check("to_popclr", timeout_irq, 1'b0);
    check("to_empty", bus.rd_valid, 1'b0);

    // Disable during a frame: STOP captures the last character, OFF ignores later ones
    bus.rx_busy = 1; ctrl_en = 0; cycle();
    check("stop_en", bus.rx_en, 1'b0);
    push(8'h77, 0);
    check("stop_cap", fifo_count, 1);
    bus.rx_busy = 0; cycle();
    push(8'h88, 0);
    check("off_ignore", fifo_count, 1);
    bus.rd_ready = 1; cycle(); bus.rd_ready = 0;

    // Flush with three entries, coinciding with a write
    ctrl_en = 1; repeat (RSTC + 2) cycle();
    push(8'h01, 0); push(8'h02, 0); push(8'h03, 0);
    check("pre_flush", fifo_count, 3);
    ctrl_flush = 1; bus.rx_done = 1; bus.rx_data = 8'h04;
    cycle();
    ctrl_flush = 0; bus.rx_done = 0;
    check("flushed", fifo_count, 0);
    repeat (RSTC + 1) cycle();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      ctrl_en      = ($urandom % 24) != 0;
      ctrl_flush   = ($urandom % 60) == 0;
      err_clr      = ($urandom % 25) == 0;
      bus.rx_done  = ($urandom % 3) == 0;
      bus.rx_error = ($urandom % 8) == 0;
      bus.rx_busy  = ($urandom % 4) == 0;
      bus.rd_ready = ($urandom % 4) == 0;
      bus.rx_data  = 8'($urandom);
      cycle();
    end
    ctrl_flush = 0; err_clr = 0; bus.rx_done = 0; bus.rx_error = 0;
    bus.rx_busy = 0; bus.rd_ready = 0;

    // Asynchronous reset mid-operation
    ctrl_en = 1; repeat (RSTC + 2) cycle();
    push(8'hC3, 0); push(8'h3C, 0);
    #2; arst_n = 1'b0; #1;
    model_reset();
    check_all();
    ctrl_en = 0;
    @(negedge clk); arst_n = 1'b1;
    cycle(); cycle();
    push(8'h99, 0);
    check("post_rst_off", fifo_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
